// File: rtl/gate_tt_sequencer_pkg.sv
// Shared definitions for the gate truth-table sequencer: gate indices, golden
// tables, FSM state encoding and the settle-counter width rule.
package gate_tt_pkg;

    localparam int N_GATES = 7;
    localparam int TT_W    = 4 * N_GATES;

    localparam int G_AND  = 0;
    localparam int G_OR   = 1;
    localparam int G_NAND = 2;
    localparam int G_NOR  = 3;
    localparam int G_XOR  = 4;
    localparam int G_XNOR = 5;
    localparam int G_NOTA = 6;

    // Bit i of each nibble is the gate output for {a,b} == i.
    localparam logic [3:0] GOLD_AND  = 4'b1000;
    localparam logic [3:0] GOLD_OR   = 4'b1110;
    localparam logic [3:0] GOLD_NAND = 4'b0111;
    localparam logic [3:0] GOLD_NOR  = 4'b0001;
    localparam logic [3:0] GOLD_XOR  = 4'b0110;
    localparam logic [3:0] GOLD_XNOR = 4'b1001;
    localparam logic [3:0] GOLD_NOTA = 4'b0011;

    localparam logic [TT_W-1:0] GOLDEN_TT = {GOLD_NOTA, GOLD_XNOR, GOLD_XOR, GOLD_NOR,
                                             GOLD_NAND, GOLD_OR, GOLD_AND};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } tt_state_e;

    function automatic int cnt_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/gate_tt_sequencer_if.sv
// Signal bundle between the sequencer, the start source and the gate datapath.
interface gate_tt_sequencer_if;
    import gate_tt_pkg::*;

    // start is a level honoured only while idle; busy spans accept..done;
    // done is a single-cycle pulse marking tt_out/fail_mask/pass as valid.
    logic               start;
    logic [N_GATES-1:0] y_in;
    logic               drv_a;
    logic               drv_b;
    logic               busy;
    logic               done;
    logic [TT_W-1:0]    tt_out;
    logic [N_GATES-1:0] fail_mask;
    logic               pass;
    tt_state_e          state;

    modport master (
        input  start, y_in,
        output drv_a, drv_b, busy, done, tt_out, fail_mask, pass, state
    );

    modport slave (
        output start, y_in,
        input  drv_a, drv_b, busy, done, tt_out, fail_mask, pass, state
    );

endinterface

// File: rtl/gate_tt_sequencer_settle_timer.sv
// Loadable down-counter that paces the settle delay after each operand vector.
module settle_timer #(
    parameter int           W        = 2,
    parameter logic [W-1:0] LOAD_VAL = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_tt_sequencer.sv
// Walks the gate datapath through all four operand vectors, captures a 28-bit
// truth table and grades each gate against its golden table.
module gate_tt_sequencer
    import gate_tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    gate_tt_sequencer_if.master  bus
);

    localparam int           CW          = cnt_width(SETTLE_CYCLES);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);

    tt_state_e          state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic               drv_a_q, drv_a_d;
    logic               drv_b_q, drv_b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [TT_W-1:0]    tt_q, tt_d;
    logic [N_GATES-1:0] fail_q, fail_d;
    logic               tmr_load;
    logic               tmr_dec;
    logic               tmr_zero;

    settle_timer #(
        .W        (CW),
        .LOAD_VAL (SETTLE_LOAD)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_load),
        .dec_i  (tmr_dec),
        .zero_o (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        drv_a_d  = drv_a_q;
        drv_b_d  = drv_b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        tt_d     = tt_q;
        fail_d   = fail_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    idx_d    = 2'd0;
                    drv_a_d  = 1'b0;
                    drv_b_d  = 1'b0;
                    busy_d   = 1'b1;
                    tt_d     = '0;
                    fail_d   = '0;
                    pass_d   = 1'b0;
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_SAMPLE: begin
                // idx is the {a,b} vector currently on the pins, so it picks the bit within each nibble.
                for (int g = 0; g < N_GATES; g++) begin
                    tt_d[{g[2:0], idx_q}] = bus.y_in[g];
                end
                if (idx_q == 2'd3) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d              = idx_q + 2'd1;
                    {drv_a_d, drv_b_d} = idx_q + 2'd1;
                    tmr_load           = 1'b1;
                    state_d            = ST_SETTLE;
                end
            end

            ST_FINISH: begin
                for (int g = 0; g < N_GATES; g++) begin
                    fail_d[g] = |(tt_q[{g[2:0], 2'b00} +: 4] ^ GOLDEN_TT[{g[2:0], 2'b00} +: 4]);
                end
                pass_d  = ~|fail_d;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            drv_a_q <= 1'b0;
            drv_b_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tt_q    <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drv_a_q <= drv_a_d;
            drv_b_q <= drv_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tt_q    <= tt_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.drv_a     = drv_a_q;
    assign bus.drv_b     = drv_b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.tt_out    = tt_q;
    assign bus.fail_mask = fail_q;
    assign bus.pass      = pass_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: a behavioural gate datapath with injectable
// per-vector faults feeds two instances (settle 2 and settle 0).
module tb_gate_tt_sequencer;
    import gate_tt_pkg::*;

    localparam int W = 36;

    logic clk;
    logic rst_n;
    logic [27:0] flip_tt;
    logic sel;
    int tests;
    int fails;
    logic [W-1:0] exp_q[$];

    gate_tt_sequencer_if bus2 ();
    gate_tt_sequencer_if bus0 ();

    gate_tt_sequencer #(.SETTLE_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    gate_tt_sequencer #(.SETTLE_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // ---------------- reference gate datapath ----------------
    function automatic logic [6:0] gates(input logic a, input logic b);
        return {~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    endfunction

    function automatic logic [6:0] flip_at(input logic [27:0] f, input logic [1:0] v);
        logic [6:0] r = '0;
        logic [27:0] sh;
        for (int g = 0; g < 7; g++) begin
            sh = f >> (4 * g + int'(v));
            if (sh[0]) r = r | (7'd1 << g);
        end
        return r;
    endfunction

    function automatic logic [27:0] ideal_tt();
        logic [27:0] t = '0;
        logic [1:0] v;
        logic [6:0] gv;
        for (int i = 0; i < 4; i++) begin
            v  = 2'(i);
            gv = gates(v[1], v[0]);
            for (int g = 0; g < 7; g++) begin
                if (((gv >> g) & 7'd1) != 7'd0) t = t | (28'd1 << (4 * g + i));
            end
        end
        return t;
    endfunction

    function automatic logic [6:0] exp_fail(input logic [27:0] flip);
        logic [6:0] r = '0;
        for (int g = 0; g < 7; g++) begin
            if (((flip >> (4 * g)) & 28'hF) != 28'd0) r = r | (7'd1 << g);
        end
        return r;
    endfunction

    always_comb bus2.y_in = gates(bus2.drv_a, bus2.drv_b) ^ flip_at(flip_tt, {bus2.drv_a, bus2.drv_b});
    always_comb bus0.y_in = gates(bus0.drv_a, bus0.drv_b) ^ flip_at(flip_tt, {bus0.drv_a, bus0.drv_b});

    logic        m_done, m_busy, m_drv_a, m_drv_b, m_pass;
    logic [27:0] m_tt;
    logic [6:0]  m_fail;
    assign m_done  = sel ? bus2.done      : bus0.done;
    assign m_busy  = sel ? bus2.busy      : bus0.busy;
    assign m_drv_a = sel ? bus2.drv_a     : bus0.drv_a;
    assign m_drv_b = sel ? bus2.drv_b     : bus0.drv_b;
    assign m_pass  = sel ? bus2.pass      : bus0.pass;
    assign m_tt    = sel ? bus2.tt_out    : bus0.tt_out;
    assign m_fail  = sel ? bus2.fail_mask : bus0.fail_mask;

    // ---------------- driver / check tasks ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic s, input logic v);
        if (s) bus2.start = v;
        else   bus0.start = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":drv_a"}, 64'(bus2.drv_a), 64'd0);
        check({tag, ":drv_b"}, 64'(bus2.drv_b), 64'd0);
        check({tag, ":busy"},  64'(bus2.busy),  64'd0);
        check({tag, ":done"},  64'(bus2.done),  64'd0);
        check({tag, ":tt"},    64'(bus2.tt_out), 64'd0);
        check({tag, ":fail"},  64'(bus2.fail_mask), 64'd0);
        check({tag, ":pass"},  64'(bus2.pass),  64'd0);
        check({tag, ":state"}, 64'(bus2.state), 64'(ST_IDLE));
    endtask

    // One complete run from a start pulse; scores timing, drive sequence and results.
    task automatic run_check(input logic s, input logic [27:0] flip, input string tag,
                             input bit repulse, input int quiet);
        int settle, k, done_edge, busy_bad, n_done, n;
        logic [1:0] exp_drv[$];
        logic [1:0] got_drv[$];
        logic [W-1:0] e;
        sel      = s;
        settle   = s ? 2 : 0;
        flip_tt  = flip;
        exp_q.push_back({(flip == 28'd0), exp_fail(flip), ideal_tt() ^ flip});
        for (int v = 0; v < 4; v++)
            for (int r = 0; r < settle + 2; r++) exp_drv.push_back(2'(v));
        exp_drv.push_back(2'd3);

        set_start(s, 1'b1);
        k = 0; done_edge = -1; busy_bad = 0;
        while (done_edge < 0 && k < 300) begin
            @(negedge clk);
            k++;
            set_start(s, repulse && (k == 3 || k == 10));
            if (m_done) done_edge = k - 1;
            else begin
                got_drv.push_back({m_drv_a, m_drv_b});
                if (!m_busy) busy_bad++;
            end
        end
        set_start(s, 1'b0);

        check({tag, ":done_edge"}, 64'(done_edge), 64'(4 * (settle + 2) + 1));
        check({tag, ":busy_before_done"}, 64'(busy_bad), 64'd0);
        check({tag, ":busy_at_done"}, 64'(m_busy), 64'd0);
        e = exp_q.pop_front();
        check({tag, ":tt"},   64'(m_tt),   64'(e[27:0]));
        check({tag, ":fail"}, 64'(m_fail), 64'(e[34:28]));
        check({tag, ":pass"}, 64'(m_pass), 64'(e[35]));
        check({tag, ":drv_len"}, 64'(got_drv.size()), 64'(exp_drv.size()));
        n = (got_drv.size() < exp_drv.size()) ? got_drv.size() : exp_drv.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s:drv[%0d]", tag, i), 64'(got_drv[i]), 64'(exp_drv[i]));

        n_done = 0;
        for (int i = 0; i < quiet; i++) begin
            @(negedge clk);
            if (m_done) n_done++;
        end
        check({tag, ":extra_done"}, 64'(n_done), 64'd0);
        check({tag, ":tt_persist"}, 64'(m_tt), 64'(e[27:0]));
        check({tag, ":pass_persist"}, 64'(m_pass), 64'(e[35]));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int k, nd;
        int d[3];
        logic [27:0] f;
        logic s;
        tests = 0; fails = 0;
        rst_n = 1'b0; bus2.start = 1'b0; bus0.start = 1'b0;
        flip_tt = '0; sel = 1'b1;

        repeat (3) @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset_released");

        run_check(1'b1, 28'd0, "golden_s2", 1'b0, 4);
        run_check(1'b1, 28'hF << 16, "xor_as_xnor", 1'b0, 2);
        run_check(1'b1, ideal_tt(), "stuck_zero", 1'b0, 2);
        run_check(1'b0, 28'd0, "golden_s0", 1'b0, 3);

        // Asynchronous reset landing mid-run.
        sel = 1'b1; flip_tt = '0;
        set_start(1'b1, 1'b1);
        @(negedge clk);
        set_start(1'b1, 1'b0);
        check("midrun_busy", 64'(bus2.busy), 64'd1);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus2.done) nd++;
        end
        check("midrun_no_done", 64'(nd), 64'd0);
        run_check(1'b1, 28'd0, "after_reset", 1'b0, 2);

        run_check(1'b1, 28'd0, "start_repulse", 1'b1, 25);

        // start held high: back-to-back runs.
        sel = 1'b1; flip_tt = '0;
        set_start(1'b1, 1'b1);
        k = 0; nd = 0;
        while (nd < 3 && k < 200) begin
            @(negedge clk);
            k++;
            if (bus2.done) begin
                d[nd] = k - 1;
                check($sformatf("held_pass[%0d]", nd), 64'(bus2.pass), 64'd1);
                nd++;
                if (nd == 3) set_start(1'b1, 1'b0);
            end
        end
        set_start(1'b1, 1'b0);
        check("held_count", 64'(nd), 64'd3);
        check("held_first", 64'(d[0]), 64'd17);
        check("held_gap0", 64'(d[1] - d[0]), 64'd18);
        check("held_gap1", 64'(d[2] - d[1]), 64'd18);
        repeat (3) @(negedge clk);
        check("held_idle", 64'(bus2.state), 64'(ST_IDLE));

        for (int r = 0; r < 8; r++) begin
            f = ($urandom_range(0, 3) == 0) ? 28'd0 : 28'($urandom);
            s = 1'($urandom_range(0, 1));
            run_check(s, f, $sformatf("rand%0d", r), 1'b0, 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
